// File: rtl/raifes_pc_gen_if.sv
// -----------------------------------------------------------------------------
// raifes_pc_gen_if
//   Bundle of every signal exchanged between the raifes control/DX logic and
//   the program-counter unit (raifes_pc_gen). Clock and reset are not part of
//   the bundle; they stay plain ports on the module.
//
//   master : control unit / DX stage side (drives selects, operands, RAS ops)
//   slave  : raifes_pc_gen side (drives the next/fetch PC and RAS outputs)
//
//   Signals
//     PC_src_sel        3   next-PC source: SEQ, REPLAY, BRANCH, JAL, JALR,
//                           HANDLER, EPC, DPC (0..7)
//     stall_IF          1   hold fetch PC (honoured for SEQ only)
//     inst_DX           32  DX instruction, source of B/J/I immediates
//     inst_IF_is16      1   fetched instruction is 16-bit (compressed builds)
//     rs1_data          X   JALR base register value
//     PC_DX             X   PC of the DX instruction
//     handler_PC        X   trap handler target
//     epc, dpc          X   xRET and debug-return targets
//     ras_push/ras_pop  1   DX instruction is a call / a return
//     link_is16         1   DX instruction is 16-bit (link = PC_DX+2)
//     ras_flush         1   empty the return-address stack
//     PC_PIF            X   combinational next PC
//     PC_IF             X   registered fetch PC
//     target_misaligned 1   registered misaligned-target flag
//     ras_top           X   current return prediction (0 when empty)
//     ras_valid         1   return-address stack non-empty
// -----------------------------------------------------------------------------
interface raifes_pc_gen_if #(
  parameter int XPR_LEN = 32
);

  logic [2:0]         PC_src_sel;
  logic               stall_IF;
  logic [31:0]        inst_DX;
  logic               inst_IF_is16;
  logic [XPR_LEN-1:0] rs1_data;
  logic [XPR_LEN-1:0] PC_DX;
  logic [XPR_LEN-1:0] handler_PC;
  logic [XPR_LEN-1:0] epc;
  logic [XPR_LEN-1:0] dpc;
  logic               ras_push;
  logic               ras_pop;
  logic               link_is16;
  logic               ras_flush;

  logic [XPR_LEN-1:0] PC_PIF;
  logic [XPR_LEN-1:0] PC_IF;
  logic               target_misaligned;
  logic [XPR_LEN-1:0] ras_top;
  logic               ras_valid;

  modport master (
    output PC_src_sel, stall_IF, inst_DX, inst_IF_is16, rs1_data, PC_DX,
           handler_PC, epc, dpc, ras_push, ras_pop, link_is16, ras_flush,
    input  PC_PIF, PC_IF, target_misaligned, ras_top, ras_valid
  );

  modport slave (
    input  PC_src_sel, stall_IF, inst_DX, inst_IF_is16, rs1_data, PC_DX,
           handler_PC, epc, dpc, ras_push, ras_pop, link_is16, ras_flush,
    output PC_PIF, PC_IF, target_misaligned, ras_top, ras_valid
  );

endinterface

// File: rtl/raifes_pc_gen.sv
// -----------------------------------------------------------------------------
// raifes_pc_gen
//   Program-counter unit of the raifes core. Selects the next PC (PC_PIF),
//   holds the architectural fetch PC (PC_IF), flags misaligned computed
//   targets, and keeps a circular return-address stack (RAS) that predicts
//   JALR returns.
//
//   Parameters
//     XPR_LEN      datapath / PC width (>= 32)
//     RESET_VECTOR PC_IF value after reset
//     RAS_DEPTH    RAS entries, power of two, >= 2
//     C_EXT        1 = compressed support: 2-byte alignment, 16-bit step
//
//   Ports
//     clk     rising-edge core clock
//     nreset  synchronous active-low reset, priority over all inputs
//     bus     raifes_pc_gen_if.slave (selects, operands, RAS ops in;
//             PC_PIF, PC_IF, target_misaligned, ras_top, ras_valid out)
// -----------------------------------------------------------------------------
module raifes_pc_gen #(
  parameter int                 XPR_LEN      = 32,
  parameter logic [XPR_LEN-1:0] RESET_VECTOR = '0,
  parameter int                 RAS_DEPTH    = 4,
  parameter bit                 C_EXT        = 1'b0
) (
  input  logic             clk,
  input  logic             nreset,
  raifes_pc_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    SEL_SEQ     = 3'd0,
    SEL_REPLAY  = 3'd1,
    SEL_BRANCH  = 3'd2,
    SEL_JAL     = 3'd3,
    SEL_JALR    = 3'd4,
    SEL_HANDLER = 3'd5,
    SEL_EPC     = 3'd6,
    SEL_DPC     = 3'd7
  } pc_sel_e;

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pc_sel_e sel;
  assign sel = pc_sel_e'(bus.PC_src_sel);

  // ---------------------------------------------------------------------------
  // Immediate decode (RISC-V B/J/I formats), sign-extended to XPR_LEN
  // ---------------------------------------------------------------------------
  logic [XPR_LEN-1:0] imm_i;
  logic [XPR_LEN-1:0] imm_b;
  logic [XPR_LEN-1:0] imm_j;

  assign imm_i = XPR_LEN'($signed(bus.inst_DX[31:20]));
  assign imm_b = XPR_LEN'($signed({bus.inst_DX[31], bus.inst_DX[7],
                                    bus.inst_DX[30:25], bus.inst_DX[11:8],
                                    1'b0}));
  assign imm_j = XPR_LEN'($signed({bus.inst_DX[31], bus.inst_DX[19:12],
                                    bus.inst_DX[20], bus.inst_DX[30:21],
                                    1'b0}));

  // Opcode bits carry no target information here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^bus.inst_DX[6:0];

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  logic [XPR_LEN-1:0] pc_if_q;
  logic [XPR_LEN-1:0] pc_pif;
  logic [XPR_LEN-1:0] seq_step;
  logic [XPR_LEN-1:0] jalr_sum;
  logic               is_jump;
  logic               misaligned;
  logic               pc_load;

  assign seq_step = (C_EXT && bus.inst_IF_is16) ? XPR_LEN'(2) : XPR_LEN'(4);
  assign jalr_sum = bus.rs1_data + imm_i;

  logic unused_jalr_lsb;
  assign unused_jalr_lsb = jalr_sum[0];

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    pc_pif = pc_if_q;
    unique case (sel)
      SEL_SEQ:     pc_pif = pc_if_q + seq_step;
      SEL_REPLAY:  pc_pif = pc_if_q;
      SEL_BRANCH:  pc_pif = bus.PC_DX + imm_b;
      SEL_JAL:     pc_pif = bus.PC_DX + imm_j;
      SEL_JALR:    pc_pif = {jalr_sum[XPR_LEN-1:1], 1'b0};
      SEL_HANDLER: pc_pif = bus.handler_PC;
      SEL_EPC:     pc_pif = bus.epc;
      SEL_DPC:     pc_pif = bus.dpc;
      default:     pc_pif = pc_if_q;
    endcase
  end

  // Only computed targets are checked; bit 0 is zero by construction for
  // branch/JAL immediates and forced to zero for JALR, so bit 1 decides.
  assign is_jump    = (sel == SEL_BRANCH) || (sel == SEL_JAL) || (sel == SEL_JALR);
  assign misaligned = is_jump && !C_EXT && pc_pif[1];

  // Redirects (2..7) ignore stall_IF; a misaligned computed target leaves the
  // fetch PC alone so the control unit can take the trap with a clean PC_IF.
  always_comb begin
    pc_load = 1'b0;
    if (is_jump) begin
      pc_load = !misaligned;
    end else if (sel == SEL_SEQ) begin
      pc_load = !bus.stall_IF;
    end else if (sel == SEL_REPLAY) begin
      pc_load = 1'b0;
    end else begin
      pc_load = 1'b1;
    end
  end

  logic tm_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pc_if_q <= RESET_VECTOR;
      tm_q    <= 1'b0;
    end else begin
      tm_q <= misaligned;
      if (pc_load) begin
        pc_if_q <= pc_pif;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return-address stack
  //   ptr_q points at the current top entry; cnt_q saturates at RAS_DEPTH so a
  //   push on a full stack silently overwrites the oldest entry.
  // ---------------------------------------------------------------------------
  logic [XPR_LEN-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               wr_en;
  logic               ras_empty;
  logic               ras_full;
  logic [XPR_LEN-1:0] link;

  assign link      = bus.PC_DX + (bus.link_is16 ? XPR_LEN'(2) : XPR_LEN'(4));
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (bus.ras_flush) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (bus.ras_push && (!bus.ras_pop || ras_empty)) begin
      // Plain push; push+pop on an empty stack degenerates to a push.
      ptr_d  = ptr_q + PTR_W'(1);
      wr_ptr = ptr_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (!ras_full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.ras_push && bus.ras_pop) begin
      // Return immediately followed by a call: replace the top in place.
      wr_en  = 1'b1;
      wr_ptr = ptr_q;
    end else if (bus.ras_pop && !ras_empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the stack entries are deliberately left out of reset; the count
  // alone decides validity, and ras_top is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (nreset && wr_en) begin
      ras_mem[wr_ptr] <= link;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.PC_PIF            = pc_pif;
  assign bus.PC_IF             = pc_if_q;
  assign bus.target_misaligned = tm_q;
  assign bus.ras_valid         = !ras_empty;
  assign bus.ras_top           = ras_empty ? '0 : ras_mem[ptr_q];

endmodule

// File: doc/raifes_pc_gen.md
Name: raifes_pc_gen

Overview:
Next-generation program-counter unit for the raifes core. It combines next-PC selection with the architectural fetch PC register (PC_IF) and a parametrised return-address stack (RAS) that predicts JALR returns. It adds misaligned-target detection and optional 16-bit sequential increment for compressed instructions. It sits between the control unit (redirect select, stall) and the fetch stage.

Parameters:
XPR_LEN, 32, datapath/PC width
RESET_VECTOR, 32'h0000_0000, PC_IF value after reset
RAS_DEPTH, 4, RAS entries; power of 2, at least 2
C_EXT, 0, 1 = compressed support: 2-byte alignment and 16-bit sequential step

Ports:
clk  in  1  core clock, rising edge
nreset  in  1  synchronous, active-low reset
PC_src_sel  in  3  0 SEQ, 1 REPLAY, 2 BRANCH, 3 JAL, 4 JALR, 5 HANDLER, 6 EPC, 7 DPC
stall_IF  in  1  hold fetch PC; ignored for sel 2..7
inst_DX  in  32  instruction in DX; source of B/J/I immediates
inst_IF_is16  in  1  current fetch instruction is 16-bit (used only when C_EXT=1)
rs1_data  in  XPR_LEN  JALR base
PC_DX  in  XPR_LEN  PC of the DX instruction
handler_PC, epc, dpc  in  XPR_LEN each  trap, xRET and debug targets
ras_push  in  1  DX is a call (link register x1/x5)
ras_pop  in  1  DX is a return
link_is16  in  1  DX instruction is 16-bit; link = PC_DX+2, else PC_DX+4
ras_flush  in  1  empty the RAS
PC_PIF  out  XPR_LEN  combinational next PC
PC_IF  out  XPR_LEN  registered fetch PC
target_misaligned  out  1  registered; computed jump/branch target misaligned
ras_top  out  XPR_LEN  current top-of-stack prediction
ras_valid  out  1  RAS non-empty

Behaviour:
- Reset (nreset=0 at a clk edge): PC_IF=RESET_VECTOR, target_misaligned=0, RAS count=0 and pointer=0, ras_valid=0, ras_top=0 (entries need not clear). Reset has priority over every other input.
- Targets, all modulo 2^XPR_LEN:
  - SEQ: PC_IF+4, or PC_IF+2 when C_EXT=1 and inst_IF_is16=1.
  - REPLAY: PC_IF.
  - BRANCH: PC_DX+imm_b.
  - JAL: PC_DX+imm_j.
  - JALR: (rs1_data + sign-extended imm_i) with bit0 forced to 0.
  - HANDLER, EPC, DPC: the raw input.
- Misaligned check: applies only to sel 2..4. A target is misaligned when bit1=1 and C_EXT=0; bit0 is never set for these selects.
- PC_PIF is purely combinational, zero latency.
- PC_IF update at each clk edge when not in reset:
  - sel 2..7: PC_IF<=PC_PIF regardless of stall_IF. Exception: a misaligned 2..4 target leaves PC_IF unchanged.
  - sel SEQ with stall_IF=0: PC_IF<=PC_PIF.
  - sel SEQ with stall_IF=1, or sel REPLAY: PC_IF unchanged.
- target_misaligned: set for exactly one cycle following a misaligned 2..4 select, otherwise 0. The control unit is expected to select HANDLER next.
- RAS: circular buffer of RAS_DEPTH entries, top pointer, and count saturating at RAS_DEPTH. ras_top = entry[ptr]; ras_valid = count!=0.
  - push only: ptr+1 (wraps), write link, count+1 saturating. Push on full overwrites the oldest entry.
  - pop only: ptr-1 (wraps), count-1. Pop on empty: no change.
  - push and pop together: overwrite entry[ptr] with link; ptr and count unchanged. On empty this behaves as push.
  - ras_flush: count<=0, ptr<=0. Overrides push/pop in the same cycle.
  - RAS updates are gated by neither stall_IF nor target_misaligned. The control unit asserts push/pop exactly once per retired DX instruction.
- No internal state besides PC_IF, target_misaligned and the RAS.

Test Plan:
- Reset then SEQ, stall_IF=0, 3 cycles -> PC_IF 0x0, 0x4, 0x8, 0xC. With C_EXT=1 and inst_IF_is16=1 -> step of 2.
- stall_IF=1 with SEQ -> PC_IF holds. Same cycle with sel=JAL, PC_DX=0x100, imm_j=-8 -> PC_IF=0xF8 next cycle.
- JALR with rs1_data=0x203, imm_i=0 -> PC_PIF=0x202. C_EXT=0 -> target_misaligned=1 for one cycle, PC_IF unchanged. C_EXT=1 -> PC_IF=0x202, no flag.
- RAS_DEPTH=4: push links 0x14, 0x24, 0x34, 0x44, 0x54 -> ras_top=0x54, count 4. Four pops -> tops 0x44, 0x34, 0x24, then ras_valid=0. Fifth pop -> no change.
- Push and pop together with top=0x44, PC_DX=0x80, link_is16=0 -> ras_top=0x84, count unchanged. ras_flush together with push -> ras_valid=0.
- nreset asserted mid-stream with PC_IF=0x1234 and RAS count 3 -> next edge PC_IF=RESET_VECTOR, ras_valid=0, target_misaligned=0. PC wrap: PC_IF=0xFFFF_FFFC, SEQ -> 0x0.
